ffa_requester: RTL and testbench

Initiator-side controller for the flip-flop register array. It accepts read/write commands over a valid/ready handshake and drives the array's `din`/`addr`/`wr`/`rd` strobes, never asserting `wr` and `rd` together. It keeps a shadow valid bitmap so reads of never-written entries are rejected locally without touching the array. It returns one response per command with backpressure, and sits between the command fabric and one array instance.

---
 rtl/ffa_requester.sv | 162 ++++++++++++++++
 tb/tb_ffa_requester.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ffa_requester.sv
`default_nettype none
// ============================================================================
// Module   : ffa_requester
// Brief    : Initiator-side controller for the flip-flop register array.
//            Accepts read/write commands, drives the array strobes, keeps a
//            shadow valid bitmap to reject reads of never-written entries
//            locally, and returns one response per command with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module ffa_requester #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_N = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] arr_din,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              arr_wr,
  output logic              arr_rd,
  input  logic [DATA_W-1:0] arr_dout,
  input  logic              arr_error,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                cmd_wr_q,    cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
  logic [DATA_W-1:0]   cmd_data_q,  cmd_data_d;
  logic [DATA_N-1:0]   shadow_q,    shadow_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [ADDR_W-1:0]   arr_addr_q,  arr_addr_d;
  logic [DATA_W-1:0]   arr_din_q,   arr_din_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  logic addr_ok;
  logic entry_valid;

  // Classify the incoming command: in-range address and shadow bit lookup.
  always_comb begin
    addr_ok     = (int'(cmd_addr) < DATA_N);
    entry_valid = 1'b0;
    for (int i = 0; i < DATA_N; i++) begin
      if (cmd_addr == ADDR_W'(i)) entry_valid = shadow_q[i];
    end
  end

  // Next-state and datapath updates for the IDLE -> ISSUE -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    shadow_d    = shadow_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    arr_addr_d  = arr_addr_q;
    arr_din_d   = arr_din_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_wr_d   = cmd_wr;
          cmd_addr_d = cmd_addr;
          cmd_data_d = cmd_data;
          // Out-of-range or never-written reads are answered without the array.
          if (!addr_ok || (!cmd_wr && !entry_valid)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = RESP;
          end else begin
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Remember what was driven so the array pins hold after the strobe.
        arr_addr_d = cmd_addr_q;
        if (cmd_wr_q) begin
          arr_din_d  = cmd_data_q;
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          for (int i = 0; i < DATA_N; i++) begin
            if (cmd_addr_q == ADDR_W'(i)) shadow_d[i] = 1'b1;
          end
        end else begin
          rsp_data_d = arr_dout;
          rsp_err_d  = arr_error;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (rsp_err_q && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      shadow_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      arr_addr_q  <= '0;
      arr_din_q   <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      shadow_q    <= shadow_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      arr_addr_q  <= arr_addr_d;
      arr_din_q   <= arr_din_d;
      err_count_q <= err_count_d;
    end
  end

  // Output decode: strobes exist only in ISSUE, so wr and rd are exclusive.
  always_comb begin
    cmd_ready = (state_q == IDLE) && !reset;
    rsp_valid = (state_q == RESP);
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
    err_count = err_count_q;
    arr_wr    = (state_q == ISSUE) &&  cmd_wr_q;
    arr_rd    = (state_q == ISSUE) && !cmd_wr_q;
    arr_addr  = (state_q == ISSUE) ? cmd_addr_q : arr_addr_q;
    arr_din   = ((state_q == ISSUE) && cmd_wr_q) ? cmd_data_q : arr_din_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ffa_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_ffa_requester
// Brief    : Directed self-checking bench for ffa_requester (DATA_N=6, CNT_W=2)
//            with a small behavioural register array attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ffa_requester;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DN = 6;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [DW-1:0] arr_din;
  logic [AW-1:0] arr_addr;
  logic          arr_wr;
  logic          arr_rd;
  logic [DW-1:0] arr_dout;
  logic          arr_error;
  logic [CW-1:0] err_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          arr_err_drv;

  int n_checks;
  int n_fail;
  int exp_cnt;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;

  ffa_requester #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DATA_N (DN),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .arr_din   (arr_din),
    .arr_addr  (arr_addr),
    .arr_wr    (arr_wr),
    .arr_rd    (arr_rd),
    .arr_dout  (arr_dout),
    .arr_error (arr_error),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: write on strobe, combinational read data.
  always @(posedge clk) begin
    if (arr_wr) mem[arr_addr] <= arr_din;
  end
  assign arr_dout  = mem[arr_addr];
  assign arr_error = arr_err_drv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command end to end; hold = number of RESP cycles with rsp_ready low.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input bit local_err, input logic [DW-1:0] exp_data, input logic exp_err,
                         input bit arr_err, input int hold);
    int n_resp;
    n_resp = (hold == 0) ? 1 : hold;
    @(negedge clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_wr      = wr;
    cmd_addr    = addr;
    cmd_data    = data;
    arr_err_drv = arr_err;
    rsp_ready   = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'hEE;
    if (local_err) begin
      check_eq("local_no_wr", 32'(arr_wr), 32'd0);
      check_eq("local_no_rd", 32'(arr_rd), 32'd0);
      check_eq("local_addr_hold", 32'(arr_addr), 32'(last_addr));
      check_eq("local_din_hold", 32'(arr_din), 32'(last_din));
    end else begin
      check_eq("issue_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("issue_wr", 32'(arr_wr), 32'(wr));
      check_eq("issue_rd", 32'(arr_rd), 32'(!wr));
      check_eq("issue_addr", 32'(arr_addr), 32'(addr));
      check_eq("issue_din", 32'(arr_din), wr ? 32'(data) : 32'(last_din));
      last_addr = addr;
      if (wr) last_din = data;
      @(negedge clk);
    end
    arr_err_drv = 1'b0;
    for (int k = 0; k < n_resp; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("resp_valid", 32'(rsp_valid), 32'd1);
      check_eq("resp_data", 32'(rsp_data), 32'(exp_data));
      check_eq("resp_err", 32'(rsp_err), 32'(exp_err));
      check_eq("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("resp_no_strobe", 32'(arr_wr | arr_rd), 32'd0);
    end
    if (exp_err && exp_cnt != 3) exp_cnt++;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_err_count", 32'(err_count), 32'(exp_cnt));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_cnt     = 0;
    last_addr   = '0;
    last_din    = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b1;
    arr_err_drv = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_arr_wr", 32'(arr_wr), 32'd0);
    check_eq("rst_arr_rd", 32'(arr_rd), 32'd0);
    check_eq("rst_arr_addr", 32'(arr_addr), 32'd0);
    check_eq("rst_arr_din", 32'(arr_din), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;

    // write then read back
    run_cmd(1'b1, 3'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 3'd3, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 0);
    // never-written entry
    run_cmd(1'b0, 3'd5, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    // backpressure on a write response
    run_cmd(1'b1, 3'd1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 10);
    // array-reported error keeps the captured data
    run_cmd(1'b0, 3'd1, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1, 0);

    // reset during ISSUE of a write to entry 2
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 3'd2;
    cmd_data  = 8'h77;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("mid_issue_wr", 32'(arr_wr), 32'd1);
    check_eq("mid_issue_din", 32'(arr_din), 32'h77);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_wr", 32'(arr_wr), 32'd0);
    check_eq("mid_rst_rd", 32'(arr_rd), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("mid_rst_err_count", 32'(err_count), 32'd0);
    check_eq("mid_rst_arr_addr", 32'(arr_addr), 32'd0);
    reset     = 1'b0;
    exp_cnt   = 0;
    last_addr = '0;
    last_din  = '0;
    @(negedge clk);
    check_eq("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);

    // shadow cleared: entries 2 and 3 now rejected locally
    run_cmd(1'b0, 3'd2, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_cmd(1'b0, 3'd3, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    // bad addresses (7 and the first out-of-range entry 6), then saturation
    run_cmd(1'b0, 3'd7, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_cmd(1'b1, 3'd6, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    run_cmd(1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    // last valid entry works normally and does not move the counter
    run_cmd(1'b1, 3'd5, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 3'd5, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
